// File: rtl/branch_predictor_pkg.sv
// Shared constants, FSM state and BTB entry layout for the gshare branch predictor.
package branch_predictor_pkg;
    localparam int XLEN         = 32;
    localparam int HLEN         = 16;
    localparam int PHT_BITS     = 12;
    localparam int BTB_BITS     = 10;
    localparam int BTB_TAG_BITS = 12;
    localparam int CNT_BITS     = 2;
    localparam int OFFSET       = 2;

    typedef enum logic {BP_INIT, BP_READY} bpred_state_t;

    typedef struct packed {
        logic                    valid;
        logic [BTB_TAG_BITS-1:0] tag;
        logic [XLEN-1:0]         target;
    } btb_entry_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/branch_predictor_if.sv
// Lookup/prediction and resolution bundle between the frontend, branch unit and predictor.
interface branch_predictor_if #(parameter int HLEN = branch_predictor_pkg::HLEN);
    import branch_predictor_pkg::*;

    logic            ready_o;
    logic            valid_i;
    logic [XLEN-1:0] pc_i;
    logic            pred_valid_o;
    logic            pred_hit_o;
    logic            pred_taken_o;
    logic [XLEN-1:0] pred_target_o;
    logic [HLEN-1:0] pred_ghr_o;
    logic            res_valid_i;
    logic [XLEN-1:0] res_pc_i;
    logic [XLEN-1:0] res_target_i;
    logic            res_taken_i;
    logic            res_mispred_i;
    logic [HLEN-1:0] res_ghr_i;

    modport slave (
        output ready_o, pred_valid_o, pred_hit_o, pred_taken_o, pred_target_o, pred_ghr_o,
        input  valid_i, pc_i, res_valid_i, res_pc_i, res_target_i, res_taken_i,
               res_mispred_i, res_ghr_i
    );

    modport master (
        input  ready_o, pred_valid_o, pred_hit_o, pred_taken_o, pred_target_o, pred_ghr_o,
        output valid_i, pc_i, res_valid_i, res_pc_i, res_target_i, res_taken_i,
               res_mispred_i, res_ghr_i
    );
endinterface

// File: rtl/branch_predictor_sat_cnt.sv
// Next-value function of a saturating up/down counter used for PHT training.
module bpred_sat_cnt #(parameter int CNT_BITS = 2) (
    input  logic [CNT_BITS-1:0] cnt,
    input  logic                inc,
    output logic [CNT_BITS-1:0] nxt
);
    always_comb begin
        nxt = cnt;
        if (inc) begin
            if (cnt != '1) nxt = cnt + CNT_BITS'(1);
        end else if (cnt != '0) begin
            nxt = cnt - CNT_BITS'(1);
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// gshare direction predictor with tagged BTB, table init sweep and ghr repair.
// BPRED_SPEC_HIST_EN: speculative ghr update at lookup with repair on mispredict.
module branch_predictor #(
    parameter int HLEN     = branch_predictor_pkg::HLEN,
    parameter int PHT_BITS = branch_predictor_pkg::PHT_BITS,
    parameter int BTB_BITS = branch_predictor_pkg::BTB_BITS,
    parameter int TAG_BITS = branch_predictor_pkg::BTB_TAG_BITS,
    parameter int CNT_BITS = branch_predictor_pkg::CNT_BITS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    branch_predictor_if.slave bus
);
    import branch_predictor_pkg::*;

    localparam int                   INIT_BITS = max_int(BTB_BITS, PHT_BITS);
    localparam logic [INIT_BITS-1:0] INIT_LAST = '1;
    localparam logic [CNT_BITS-1:0]  CNT_WNT   = CNT_BITS'((1 << (CNT_BITS-1)) - 1);

    bpred_state_t          state_q, state_d;
    logic [INIT_BITS-1:0]  sweep_q;
    logic                  ready, init_we;

    btb_entry_t            btb [2**BTB_BITS];
    logic [CNT_BITS-1:0]   pht [2**PHT_BITS];
    logic [HLEN-1:0]       ghr_q, ghr_d;

    logic                  pred_valid_q, pred_hit_q, pred_taken_q;
    logic [XLEN-1:0]       pred_target_q;
    logic [HLEN-1:0]       pred_ghr_q;

    // FSM: state register / next state / outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= BP_INIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BP_INIT:  if (sweep_q == INIT_LAST) state_d = BP_READY;
            BP_READY: state_d = BP_READY;
            default:  state_d = BP_INIT;
        endcase
    end

    always_comb begin
        ready   = (state_q == BP_READY);
        init_we = (state_q == BP_INIT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)        sweep_q <= '0;
        else if (init_we) sweep_q <= sweep_q + INIT_BITS'(1);
    end

    // History folded onto the PHT index width
    logic [PHT_BITS-1:0] lk_hist, rs_hist;
    if (HLEN >= PHT_BITS) begin : g_hist_trunc
        assign lk_hist = ghr_q[PHT_BITS-1:0];
        assign rs_hist = bus.res_ghr_i[PHT_BITS-1:0];
    end else begin : g_hist_zext
        assign lk_hist = {{(PHT_BITS-HLEN){1'b0}}, ghr_q};
        assign rs_hist = {{(PHT_BITS-HLEN){1'b0}}, bus.res_ghr_i};
    end

    logic                lk_fire, lk_acc, lk_hit, lk_taken;
    logic [BTB_BITS-1:0] lk_btb_idx;
    logic [TAG_BITS-1:0] lk_tag;
    logic [PHT_BITS-1:0] lk_pht_idx;
    btb_entry_t          lk_ent;
    logic [CNT_BITS-1:0] lk_cnt;
    logic [XLEN-1:0]     lk_target;

    always_comb begin
        lk_fire    = bus.valid_i & ready;
        lk_btb_idx = bus.pc_i[OFFSET +: BTB_BITS];
        lk_tag     = bus.pc_i[OFFSET+BTB_BITS +: TAG_BITS];
        lk_pht_idx = bus.pc_i[OFFSET +: PHT_BITS] ^ lk_hist;
        lk_ent     = btb[lk_btb_idx];
        lk_cnt     = pht[lk_pht_idx];
        lk_hit     = lk_ent.valid & (lk_ent.tag == lk_tag);
        lk_taken   = lk_hit & lk_cnt[CNT_BITS-1];
        lk_target  = lk_taken ? lk_ent.target : bus.pc_i + XLEN'(4);
    end

    logic                rs_fire;
    logic [BTB_BITS-1:0] rs_btb_idx;
    logic [TAG_BITS-1:0] rs_tag;
    logic [PHT_BITS-1:0] rs_pht_idx;
    logic [CNT_BITS-1:0] rs_cnt, rs_cnt_nxt;

    always_comb begin
        rs_fire    = bus.res_valid_i & ready;
        rs_btb_idx = bus.res_pc_i[OFFSET +: BTB_BITS];
        rs_tag     = bus.res_pc_i[OFFSET+BTB_BITS +: TAG_BITS];
        rs_pht_idx = bus.res_pc_i[OFFSET +: PHT_BITS] ^ rs_hist;
        rs_cnt     = pht[rs_pht_idx];
    end

    bpred_sat_cnt #(.CNT_BITS(CNT_BITS)) u_sat_cnt (
        .cnt (rs_cnt),
        .inc (bus.res_taken_i),
        .nxt (rs_cnt_nxt)
    );

`ifdef BPRED_SPEC_HIST_EN
    logic rs_mis;
    always_comb begin
        rs_mis = rs_fire & bus.res_mispred_i;
        lk_acc = lk_fire & ~rs_mis;
        ghr_d  = ghr_q;
        if (rs_mis)               ghr_d = {bus.res_ghr_i[HLEN-2:0], bus.res_taken_i};
        else if (lk_acc & lk_hit) ghr_d = {ghr_q[HLEN-2:0], lk_taken};
    end
`else
    always_comb begin
        lk_acc = lk_fire;
        ghr_d  = ghr_q;
        if (rs_fire) ghr_d = {ghr_q[HLEN-2:0], bus.res_taken_i};
    end
`endif

    // Tables are memories: cleared by the init sweep, not by reset.
    // Reads above are combinational, so a same-cycle lookup sees pre-update contents.
    always_ff @(posedge clk_i) begin
        if (init_we) begin
            btb[sweep_q[BTB_BITS-1:0]].valid <= 1'b0;
            pht[sweep_q[PHT_BITS-1:0]]       <= CNT_WNT;
        end else if (rs_fire) begin
            pht[rs_pht_idx] <= rs_cnt_nxt;
            if (bus.res_taken_i)
                btb[rs_btb_idx] <= '{valid: 1'b1, tag: rs_tag, target: bus.res_target_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ghr_q         <= '0;
            pred_valid_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            pred_ghr_q    <= '0;
        end else begin
            ghr_q        <= ghr_d;
            pred_valid_q <= lk_acc;
            if (lk_acc) begin
                pred_hit_q    <= lk_hit;
                pred_taken_q  <= lk_taken;
                pred_target_q <= lk_target;
                pred_ghr_q    <= ghr_q;
            end
        end
    end

    assign bus.ready_o       = ready;
    assign bus.pred_valid_o  = pred_valid_q;
    assign bus.pred_hit_o    = pred_hit_q;
    assign bus.pred_taken_o  = pred_taken_q;
    assign bus.pred_target_o = pred_target_q;
    assign bus.pred_ghr_o    = pred_ghr_q;
endmodule
